tdm_demux4: RTL

- Time-division demultiplexer: receives a word-serial stream of 4-slot frames on one bus and distributes slots 0..3 onto four parallel registered outputs a, b, c, d.
- It is the receive-side counterpart of the team's 4:1 mux: a TDM transmitter multiplexes four channels onto one bus, and this block rebuilds them.
- A frame marker and a slot counter keep it aligned. Outputs update atomically once per complete frame, and a one-cycle pulse announces each new frame.

---
 rtl/tdm_demux4.sv | 95 +++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receive-side demultiplexer.
// Rebuilds four channels from a framed word-serial stream.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             sync_err
);

  localparam logic HUNT = 1'b0;
  localparam logic LOCK = 1'b1;

  logic             state;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  logic hunt;
  logic bad_fs;
  logic no_fs;

  // Classify the incoming word; the cases are mutually exclusive
  always_comb begin
    hunt   = (state == HUNT);
    bad_fs = (state == LOCK) && frame_start && (slot != 2'd0);
    no_fs  = (state == LOCK) && !frame_start && (slot == 2'd0);
  end

  // Slot tracking, shadow capture and atomic frame update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
        unique case (1'b1)
          hunt: begin
            if (frame_start) begin
              sh0   <= din;
              slot  <= 2'd1;
              state <= LOCK;
            end
          end
          bad_fs: begin
            sync_err <= 1'b1;
            sh0      <= din;
            slot     <= 2'd1;
          end
          no_fs: begin
            sync_err <= 1'b1;
            slot     <= 2'd0;
            state    <= HUNT;
          end
          default: begin
            case (slot)
              2'd0: sh0 <= din;
              2'd1: sh1 <= din;
              2'd2: sh2 <= din;
              default: begin
                a           <= sh0;
                b           <= sh1;
                c           <= sh2;
                d           <= din;
                frame_valid <= 1'b1;
              end
            endcase
            slot <= slot + 2'd1;
          end
        endcase
      end
    end
  end

endmodule
